// File: rtl/edge_detector_mc_if.sv
// Channel-level bundle for edge_detector_mc: raw inputs and controls in,
// filtered levels, edge pulses, status and counters out.
interface edge_detector_mc_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
);
    logic [NUM_CH-1:0]       a_i;
    logic [2*NUM_CH-1:0]     mode_i;
    logic [NUM_CH-1:0]       clr_i;
    logic [NUM_CH-1:0]       rising_edge_o;
    logic [NUM_CH-1:0]       falling_edge_o;
    logic [NUM_CH-1:0]       level_o;
    logic [NUM_CH-1:0]       status_o;
    logic                    irq_o;
    logic [NUM_CH*CNT_W-1:0] edge_cnt_o;

    modport master (
        output a_i, mode_i, clr_i,
        input  rising_edge_o, falling_edge_o, level_o, status_o, irq_o, edge_cnt_o
    );

    modport slave (
        input  a_i, mode_i, clr_i,
        output rising_edge_o, falling_edge_o, level_o, status_o, irq_o, edge_cnt_o
    );
endinterface

// File: rtl/edge_detector_mc.sv
// Multi-channel synchronizer + debounce filter with edge pulses, sticky
// status flags, saturating edge counters and a combined interrupt.
module edge_detector_mc #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    edge_detector_mc_if.slave  bus
);
    localparam int unsigned        DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]    DB_MAX  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0][DB_W-1:0]        db_q, db_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  level_q, level_d;
    logic [NUM_CH-1:0]                  rise_q, rise_d;
    logic [NUM_CH-1:0]                  fall_q, fall_d;
    logic [NUM_CH-1:0]                  status_q, status_d;
    logic [NUM_CH-1:0]                  synced;
    logic [NUM_CH-1:0]                  en_edge;

    // Edge qualification uses the registered pulses, so mode_i is looked at
    // only in the cycle a pulse is visible on the outputs.
    always_comb begin
        synced  = '0;
        en_edge = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            synced[c]  = sync_q[c][SYNC_STAGES-1];
            en_edge[c] = (rise_q[c] & bus.mode_i[2*c]) | (fall_q[c] & bus.mode_i[2*c+1]);
        end
    end

    always_comb begin
        sync_d   = sync_q;
        db_d     = db_q;
        level_d  = level_q;
        rise_d   = '0;
        fall_d   = '0;
        status_d = status_q;
        cnt_d    = cnt_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], bus.a_i[c]};

            if (synced[c] != level_q[c]) begin
                if (db_q[c] == DB_MAX) begin
                    level_d[c] = synced[c];
                    db_d[c]    = '0;
                    rise_d[c]  = synced[c];
                    fall_d[c]  = ~synced[c];
                end else begin
                    db_d[c] = db_q[c] + 1'b1;
                end
            end else begin
                db_d[c] = '0;
            end

            // An enabled edge beats a simultaneous clear for both flag and count.
            if (en_edge[c]) begin
                status_d[c] = 1'b1;
                if (bus.clr_i[c])
                    cnt_d[c] = CNT_W'(1);
                else if (cnt_q[c] != CNT_MAX)
                    cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (bus.clr_i[c]) begin
                status_d[c] = 1'b0;
                cnt_d[c]    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            db_q     <= '0;
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            db_q     <= db_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.level_o        = level_q;
    assign bus.rising_edge_o  = rise_q;
    assign bus.falling_edge_o = fall_q;
    assign bus.status_o       = status_q;
    assign bus.edge_cnt_o     = cnt_q;
    assign bus.irq_o          = |status_q;
endmodule

// File: doc/edge_detector_mc.md
EDGE_DETECTOR_MC -- requirements
Module: edge_detector_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-003 Parameter DEBOUNCE, default 3, consecutive stable cycles required before the filtered level changes (>=1).
REQ-004 Parameter CNT_W, default 8, width of each per-channel edge counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 a_i  input  NUM_CH  raw asynchronous channel inputs.
REQ-008 mode_i  input  2*NUM_CH  per-channel event enable, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 clr_i  input  NUM_CH  per-channel clear of status and counter.
REQ-010 rising_edge_o  output  NUM_CH  one-cycle pulse on filtered 0->1.
REQ-011 falling_edge_o  output  NUM_CH  one-cycle pulse on filtered 1->0.
REQ-012 level_o  output  NUM_CH  filtered (synchronized, debounced) level.
REQ-013 status_o  output  NUM_CH  sticky flag, set by an enabled edge.
REQ-014 irq_o  output  1  OR-reduction of status_o.
REQ-015 edge_cnt_o  output  NUM_CH*CNT_W  per-channel saturating count of enabled edges, channel c at [c*CNT_W +: CNT_W].

Function
REQ-016 Each channel SHALL pass a_i[c] through SYNC_STAGES flops; the last stage is the synced value.
REQ-017 Debounce: while synced != level_o[c], a per-channel counter SHALL increment each cycle; on the edge where it would reach DEBOUNCE, level_o[c] SHALL take the synced value and the counter SHALL return to 0.
REQ-018 Whenever synced == level_o[c], the debounce counter SHALL be 0 on the next cycle; a pulse shorter than DEBOUNCE cycles (after sync) SHALL not change level_o.
REQ-019 Total latency: a clean a_i step stable before clock edge k SHALL change level_o on edge k+SYNC_STAGES+DEBOUNCE-1.
REQ-020 rising_edge_o[c]/falling_edge_o[c] SHALL be registered and asserted for exactly the one cycle beginning on the same edge that level_o[c] changes; they SHALL not depend on mode_i.
REQ-021 An enabled edge is a rising pulse with mode bit 0 set, or a falling pulse with mode bit 1 set.
REQ-022 An enabled edge SHALL set status_o[c] on the next edge; clr_i[c] SHALL clear it; clr_i and enabled edge in the same cycle: set wins (status_o[c]=1).
REQ-023 An enabled edge SHALL increment edge_cnt for channel c; the count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 clr_i[c] SHALL zero the channel counter; clr_i with a simultaneous enabled edge SHALL load 1.
REQ-025 irq_o SHALL be registered-equivalent: high in every cycle any status_o bit is 1, combinational from status_o only.
REQ-026 Changing mode_i SHALL affect only edges pulsed after the change; it SHALL not alter filter state, status or counters.
REQ-027 Channels SHALL be fully independent; simultaneous events on all channels SHALL each be recorded.

Reset
REQ-028 reset high SHALL immediately, without a clock, force all synchronizer flops, debounce counters, level_o, edge pulses, status_o, edge_cnt_o and irq_o to 0.
REQ-029 After reset deasserts, an input held at 1 SHALL produce a rising_edge_o pulse after the normal latency (level starts at 0).
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for that transition.

Verification (defaults: NUM_CH=4, SYNC_STAGES=2, DEBOUNCE=3, CNT_W=8)
REQ-031 reset=1, a_i toggling randomly for 20 cycles -> every output 0 throughout.
REQ-032 mode ch0=01, a_i[0] 0->1 before edge k, held -> level_o[0]=1 and rising_edge_o[0]=1 for one cycle from edge k+4; status_o[0]=1, irq_o=1, count 1 from edge k+5.
REQ-033 a_i[1] high for 2 cycles then low, mode=11 -> no pulse, level_o[1] stays 0, count 0.
REQ-034 mode ch2=11, a_i[2] toggled with 10-cycle holds 300 times -> edge_cnt ch2 = 255 and stays 255.
REQ-035 clr_i[0]=1 in the cycle rising_edge_o[0] pulses (mode 01) -> status_o[0]=1, count ch0=1; clr_i[0] alone next -> both 0, irq_o=0.
REQ-036 reset asserted asynchronously 2 cycles into debounce of a_i[3] 0->1 -> outputs 0 before next clk edge; after release, held input yields a single rising pulse at full latency.
